// File: rtl/vedic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vedic_pkg
// Brief    : Shared types and widths for the Vedic multiplier tree.
// Revision : 1.0 - initial release
// ============================================================================
package vedic_pkg;

    localparam int OPW  = 2;
    localparam int RESW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PP   = 2'd1,
        SUM  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/half_adder.sv
`default_nettype none
// ============================================================================
// Module   : half_adder
// Brief    : Single-bit half adder cell shared across the Vedic stages.
// Revision : 1.0 - initial release
// ============================================================================
module half_adder (
    input  logic i_a,
    input  logic i_b,
    output logic o_sum,
    output logic o_carry
);

    assign o_sum   = i_a ^ i_b;
    assign o_carry = i_a & i_b;

endmodule
`default_nettype wire

// File: rtl/vedic_2x2.sv
`default_nettype none
// ============================================================================
// Module   : vedic_2x2
// Brief    : Registered 2x2 unsigned Vedic multiplier (start/done handshake).
// Revision : 1.0 - initial release
// ============================================================================
module vedic_2x2
    import vedic_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [OPW-1:0]  a,
    input  logic [OPW-1:0]  b,
    input  logic            start,
    output logic [RESW-1:0] result,
    output logic            done
);

    state_t          r_state;
    state_t          w_next;
    logic [OPW-1:0]  r_a;
    logic [OPW-1:0]  r_b;
    logic            r_p00;
    logic            r_p10;
    logic            r_p01;
    logic            r_p11;
    logic [RESW-1:0] r_result;
    logic            r_done;
    logic            w_accept;
    logic            w_s1;
    logic            w_c1;
    logic            w_s2;
    logic            w_c2;

    // Starts are only honoured when no product is in flight.
    assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = PP;
            PP:      w_next = SUM;
            SUM:     w_next = DONE;
            DONE:    if (w_accept) w_next = PP;
            default: w_next = IDLE;
        endcase
    end

    half_adder u_ha_lo (
        .i_a     (r_p10),
        .i_b     (r_p01),
        .o_sum   (w_s1),
        .o_carry (w_c1)
    );

    half_adder u_ha_hi (
        .i_a     (r_p11),
        .i_b     (w_c1),
        .o_sum   (w_s2),
        .o_carry (w_c2)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_p00    <= 1'b0;
            r_p10    <= 1'b0;
            r_p01    <= 1'b0;
            r_p11    <= 1'b0;
            r_result <= '0;
            r_done   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a    <= a;
                r_b    <= b;
                r_done <= 1'b0;
            end
            if (r_state == PP) begin
                r_p00 <= r_a[0] & r_b[0];
                r_p10 <= r_a[1] & r_b[0];
                r_p01 <= r_a[0] & r_b[1];
                r_p11 <= r_a[1] & r_b[1];
            end
            if (r_state == SUM) begin
                r_result <= {w_c2, w_s2, w_s1, r_p00};
                r_done   <= 1'b1;
            end
        end
    end

    assign result = r_result;
    assign done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_vedic_2x2.sv
`default_nettype none
// ============================================================================
// Module   : tb_vedic_2x2
// Brief    : Directed self-checking bench for vedic_2x2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vedic_2x2;

    logic       clk;
    logic       rst;
    logic [1:0] a;
    logic [1:0] b;
    logic       start;
    logic [3:0] result;
    logic       done;

    int n_checks = 0;
    int n_pass   = 0;

    vedic_2x2 dut (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .b      (b),
        .start  (start),
        .result (result),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Drive one start pulse; returns just after the accepting edge (E0 + 1ns).
    task automatic pulse(input logic [1:0] aa, input logic [1:0] bb);
        @(negedge clk);
        a     = aa;
        b     = bb;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input string tag);
        for (int k = 0; k < 10 && !done; k++) begin
            @(posedge clk);
            #1;
        end
        check(tag, {7'd0, done}, 8'd1);
    endtask

    initial begin
        logic ok;
        rst   = 1'b1;
        a     = 2'd0;
        b     = 2'd0;
        start = 1'b0;

        // Reset held with start toggling
        ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            start = ~start;
            a     = 2'd3;
            b     = 2'd3;
            if (result !== 4'd0 || done !== 1'b0) ok = 1'b0;
        end
        check("reset_hold", {7'd0, ok}, 8'd1);
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
        step(3);
        check("post_reset_result", {4'd0, result}, 8'd0);
        check("post_reset_done", {7'd0, done}, 8'd0);

        // Single ops with latency checks and long hold
        pulse(2'd3, 2'd3);
        check("3x3_e0_done", {7'd0, done}, 8'd0);
        step(1);
        check("3x3_e1_done", {7'd0, done}, 8'd0);
        step(1);
        check("3x3_done", {7'd0, done}, 8'd1);
        check("3x3_result", {4'd0, result}, 8'd9);
        step(230);
        check("3x3_hold_done", {7'd0, done}, 8'd1);
        check("3x3_hold_result", {4'd0, result}, 8'd9);

        pulse(2'd2, 2'd1);
        check("2x1_clear_done", {7'd0, done}, 8'd0);
        step(2);
        check("2x1_result", {4'd0, result}, 8'd2);
        step(230);
        check("2x1_hold_result", {4'd0, result}, 8'd2);

        pulse(2'd0, 2'd3);
        step(2);
        check("0x3_result", {4'd0, result}, 8'd0);
        check("0x3_done", {7'd0, done}, 8'd1);
        step(230);
        check("0x3_hold_result", {4'd0, result}, 8'd0);

        // Exhaustive sweep
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                pulse(i[1:0], j[1:0]);
                wait_done($sformatf("sweep_done_%0dx%0d", i, j));
                check($sformatf("sweep_%0dx%0d", i, j), {4'd0, result}, 8'(i * j));
            end
        end

        // Busy-ignore: second start at E0+1 must be dropped
        pulse(2'd3, 2'd2);
        @(negedge clk);
        a     = 2'd1;
        b     = 2'd1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        step(1);
        check("busy_done", {7'd0, done}, 8'd1);
        check("busy_result", {4'd0, result}, 8'd6);
        ok = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step(1);
            if (done !== 1'b1 || result !== 4'd6) ok = 1'b0;
        end
        check("busy_single_completion", {7'd0, ok}, 8'd1);

        // Operand hold after capture
        pulse(2'd2, 2'd3);
        a = 2'd1;
        b = 2'd1;
        step(2);
        check("hold_operands_result", {4'd0, result}, 8'd6);

        // Continuous start retriggers every 3 cycles with one-cycle done
        @(negedge clk);
        a     = 2'd3;
        b     = 2'd1;
        start = 1'b1;
        step(1);
        begin
            int highs;
            highs = 0;
            for (int k = 0; k < 9; k++) begin
                step(1);
                if (done) highs++;
            end
            check("retrigger_done_count", 8'(highs), 8'd3);
        end
        start = 1'b0;
        step(3);
        check("retrigger_result", {4'd0, result}, 8'd3);

        // Reset mid-operation
        pulse(2'd3, 2'd3);
        rst = 1'b1;
        #1;
        check("midrst_done", {7'd0, done}, 8'd0);
        check("midrst_result", {4'd0, result}, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        ok = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step(1);
            if (done !== 1'b0 || result !== 4'd0) ok = 1'b0;
        end
        check("midrst_no_stale", {7'd0, ok}, 8'd1);
        pulse(2'd3, 2'd2);
        wait_done("after_rst_done");
        check("after_rst_result", {4'd0, result}, 8'd6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
